// File: rtl/octavo_thread_pkg.sv
// Shared thread numbering: thread count, thread-number type and the
// one-hot helper used to turn a thread number into a per-thread mask.
package octavo_thread_pkg;

    localparam int THREAD_COUNT       = 8;
    localparam int THREAD_COUNT_WIDTH = 3;

    typedef logic [THREAD_COUNT_WIDTH-1:0] thread_t;

    function automatic logic [THREAD_COUNT-1:0] thread_onehot(
        input thread_t thread
    );
        logic [THREAD_COUNT-1:0] mask;
        mask         = '0;
        mask[thread] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/config_slot.sv
// One thread's queued configuration write: data register plus pending bit.
// Ports: clock, reset_n; set/clear drive pending, load/bcast_load take data_in;
// data and pending are the registered slot contents.
module config_slot
    import octavo_thread_pkg::*;
#(
    parameter int WORD_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  bcast_load,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  pending
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data    <= '0;
            pending <= 1'b0;
        end else begin
            if (load || bcast_load) begin
                data <= data_in;
            end
            // A new write landing on the issuing edge keeps the slot busy.
            if (set || bcast_load) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_config_scheduler.sv
// Holds per-thread configuration writes until the thread's write slot comes
// round, then pulses configuration_wren aligned with the detector's thread_write.
// Ports: clock, reset_n, next_thread, req_valid/req_broadcast/req_thread/req_data,
// req_ready, configuration_wren, configuration_data, pending, idle.
module branch_config_scheduler
    import octavo_thread_pkg::*;
#(
    parameter int WORD_WIDTH         = 36,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [THREAD_COUNT_WIDTH-1:0] next_thread,
    input  logic                          req_valid,
    input  logic                          req_broadcast,
    input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
    input  logic [WORD_WIDTH-1:0]         req_data,
    output logic                          req_ready,
    output logic                          configuration_wren,
    output logic [WORD_WIDTH-1:0]         configuration_data,
    output logic [THREAD_COUNT-1:0]       pending,
    output logic                          idle
);

    logic [WORD_WIDTH-1:0]   slot_data [THREAD_COUNT];
    logic [THREAD_COUNT-1:0] issue_mask;
    logic [THREAD_COUNT-1:0] slot_set;
    logic                    issue;
    logic                    transfer;
    logic                    bcast_load;

    assign issue = pending[next_thread];

    always_comb begin
        issue_mask = '0;
        for (int t = 0; t < THREAD_COUNT; t++) begin
            issue_mask[t] = issue &&
                (next_thread == THREAD_COUNT_WIDTH'(t));
        end
    end

    // The slot being issued this edge frees up, so it may be refilled now.
    always_comb begin
        if (req_broadcast) begin
            req_ready = (pending & ~issue_mask) == '0;
        end else begin
            req_ready = !pending[req_thread] ||
                (issue && (next_thread == req_thread));
        end
    end

    assign transfer   = req_valid && req_ready;
    assign bcast_load = transfer && req_broadcast;

    always_comb begin
        slot_set = '0;
        for (int t = 0; t < THREAD_COUNT; t++) begin
            slot_set[t] = transfer && !req_broadcast &&
                (req_thread == THREAD_COUNT_WIDTH'(t));
        end
    end

    for (genvar t = 0; t < THREAD_COUNT; t++) begin : g_slot
        config_slot #(
            .WORD_WIDTH (WORD_WIDTH)
        ) u_slot (
            .clock      (clock),
            .reset_n    (reset_n),
            .set        (slot_set[t]),
            .clear      (issue_mask[t]),
            .load       (slot_set[t]),
            .bcast_load (bcast_load),
            .data_in    (req_data),
            .data       (slot_data[t]),
            .pending    (pending[t])
        );
    end

    // Registered from next_thread so the pulse lines up with thread_write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            configuration_wren <= 1'b0;
            configuration_data <= '0;
        end else begin
            configuration_wren <= issue;
            if (issue) begin
                configuration_data <= slot_data[next_thread];
            end
        end
    end

    assign idle = (pending == '0) && !configuration_wren;

endmodule

// File: tb/tb_branch_config_scheduler.sv
// Scoreboard bench for branch_config_scheduler: per-thread expected queues
// filled on accept, drained by a monitor on every configuration_wren.
module tb_branch_config_scheduler;
    import octavo_thread_pkg::*;

    localparam int W = 36;
    localparam int N = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    next_thread = 3'd0;
    logic [2:0]    cur = 3'd0;
    logic          req_valid = 1'b0;
    logic          req_broadcast = 1'b0;
    logic [2:0]    req_thread = 3'd0;
    logic [W-1:0]  req_data = '0;
    logic          req_ready;
    logic          configuration_wren;
    logic [W-1:0]  configuration_data;
    logic [N-1:0]  pending;
    logic          idle;

    logic [W-1:0]  exp_q [N][$];
    logic [2:0]    issue_log [$];
    logic [W-1:0]  last_data = '0;
    int            run = 0;
    int            max_run = 0;
    int            n_pass = 0;
    int            n_total = 0;

    branch_config_scheduler #(
        .WORD_WIDTH         (W),
        .THREAD_COUNT       (N),
        .THREAD_COUNT_WIDTH (3)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .next_thread        (next_thread),
        .req_valid          (req_valid),
        .req_broadcast      (req_broadcast),
        .req_thread         (req_thread),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .configuration_wren (configuration_wren),
        .configuration_data (configuration_data),
        .pending            (pending),
        .idle               (idle)
    );

    always #5 clock = ~clock;

    // Shared free-running thread counter; cur is the detector's thread_write.
    always @(posedge clock) begin
        cur         <= next_thread;
        next_thread <= next_thread + 3'd1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] m;
        m = '0;
        for (int t = 0; t < N; t++)
            if (exp_q[t].size() != 0) m |= thread_onehot(thread_t'(t));
        return m;
    endfunction

    task automatic clear_model();
        for (int t = 0; t < N; t++) exp_q[t].delete();
        issue_log.delete();
        last_data = '0;
    endtask

    // Monitor: every wren must pop the front write queued for the current slot.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (configuration_wren) begin
                issue_log.push_back(cur);
                run++;
                if (run > max_run) max_run = run;
                if (exp_q[cur].size() == 0) begin
                    chk("unexpected_wren", 64'(configuration_wren), 64'd0);
                end else begin
                    last_data = exp_q[cur].pop_front();
                    chk("issue_data", 64'(configuration_data), 64'(last_data));
                end
            end else begin
                run = 0;
                chk("data_hold", 64'(configuration_data), 64'(last_data));
            end
            chk("pending", 64'(pending), 64'(model_pending()));
            chk("idle", 64'(idle),
                64'((model_pending() == '0) && !configuration_wren));
        end
    end

    task automatic drive(input logic v, input logic bc, input logic [2:0] thr,
                         input logic [W-1:0] d, output logic acc);
        logic [N-1:0] m;
        logic         exp_r;
        @(negedge clock);
        req_valid     = v;
        req_broadcast = bc;
        req_thread    = thr;
        req_data      = d;
        #1;
        m = model_pending();
        if (bc) exp_r = (m & ~thread_onehot(next_thread)) == '0;
        else    exp_r = !m[thr] || (next_thread == thr);
        chk("req_ready", 64'(req_ready), 64'(exp_r));
        acc = v && exp_r && reset_n;
        if (acc) begin
            if (bc) for (int t = 0; t < N; t++) exp_q[t].push_back(d);
            else    exp_q[thr].push_back(d);
        end
    endtask

    task automatic idle_cyc(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, '0, acc);
    endtask

    // Returns at the negedge just before the one where next_thread == k.
    task automatic wait_nt(input logic [2:0] k);
        logic [2:0] target;
        logic       found;
        target = k - 3'd1;
        found  = 1'b0;
        for (int i = 0; i < 2 * N && !found; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            if (next_thread == target) found = 1'b1;
        end
        if (!found) chk("wait_nt_timeout", 64'(next_thread), 64'(target));
    endtask

    task automatic offer_until(input logic bc, input logic [2:0] thr,
                               input logic [W-1:0] d, input int maxn);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < maxn && !acc; i++) drive(1'b1, bc, thr, d, acc);
        if (!acc) chk("accept_timeout", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [W-1:0] d;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_wren", 64'(configuration_wren), 64'd0);
        chk("reset_data", 64'(configuration_data), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_ready", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single write to thread 5 offered with next_thread 2.
        issue_log.delete();
        wait_nt(3'd2);
        drive(1'b1, 1'b0, 3'd5, 36'h123, acc);
        idle_cyc(10);
        chk("single_issue_count", 64'(issue_log.size()), 64'd1);
        if (issue_log.size() > 0)
            chk("single_issue_thread", 64'(issue_log[0]), 64'd5);

        // Back-pressure on thread 3, refill in the issuing cycle.
        wait_nt(3'd4);
        drive(1'b1, 1'b0, 3'd3, 36'hA1, acc);
        wait_nt(3'd0);
        offer_until(1'b0, 3'd3, 36'hB2, 12);
        idle_cyc(12);

        // Two back-to-back broadcasts: sixteen consecutive writes.
        max_run = 0;
        offer_until(1'b1, 3'd0, 36'hABC, 2);
        offer_until(1'b1, 3'd0, 36'hDEF, 20);
        idle_cyc(12);
        chk("bcast_run", 64'(max_run), 64'd16);

        // Thread 7 accepted before thread 1, but 1 issues first.
        issue_log.delete();
        wait_nt(3'd7);
        drive(1'b1, 1'b0, 3'd7, 36'h777, acc);
        drive(1'b1, 1'b0, 3'd1, 36'h111, acc);
        idle_cyc(10);
        chk("mixed_count", 64'(issue_log.size()), 64'd2);
        if (issue_log.size() == 2) begin
            chk("mixed_first", 64'(issue_log[0]), 64'd1);
            chk("mixed_second", 64'(issue_log[1]), 64'd7);
        end

        // Reset with every thread pending.
        drive(1'b1, 1'b1, 3'd0, 36'h5A5, acc);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("pre_reset_pending", 64'(pending), 64'hFF);
        reset_n = 1'b0;
        #1;
        clear_model();
        chk("mid_reset_wren", 64'(configuration_wren), 64'd0);
        chk("mid_reset_data", 64'(configuration_data), 64'd0);
        chk("mid_reset_pending", 64'(pending), 64'd0);
        chk("mid_reset_idle", 64'(idle), 64'd1);
        chk("mid_reset_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        idle_cyc(20);
        chk("no_wren_after_reset", 64'(issue_log.size()), 64'd0);

        // Random stream.
        for (int i = 0; i < 1000; i++) begin
            d = W'({$urandom(), $urandom()});
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
                  3'($urandom_range(0, N - 1)), d, acc);
        end
        idle_cyc(20);
        for (int t = 0; t < N; t++)
            chk("drained", 64'(exp_q[t].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_config_scheduler.md
# branch_config_scheduler

- Queues per-thread branch-configuration writes from a requester, then issues each one on the Branch Detector's configuration port.
- The Branch Detector's configuration memory is written only at its rotating `thread_write` address. This block therefore holds each request until that thread's slot comes round, then pulses `configuration_wren` in exactly that cycle.
- It sits between the memory-mapped write path (or a loader) and the detector. It shares the free-running thread counter that drives the detector's write address.

## Interface

Parameters:
- `WORD_WIDTH`, default 36: configuration word width; must match the detector's `WORD_WIDTH`.
- `THREAD_COUNT`, default 8: number of hardware threads.
- `THREAD_COUNT_WIDTH`, default 3: bits per thread number; equals clog2(`THREAD_COUNT`).

Ports:
- `clock  in  1`: the single clock; all state is rising-edge.
- `reset_n  in  1`: reset, asynchronous and active-low.
- `next_thread  in  THREAD_COUNT_WIDTH`: thread whose slot comes up on the next cycle; comes from the shared thread counter.
- `req_valid  in  1`: a configuration request is offered.
- `req_broadcast  in  1`: write `req_data` to every thread; `req_thread` is ignored.
- `req_thread  in  THREAD_COUNT_WIDTH`: target thread.
- `req_data  in  WORD_WIDTH`: configuration word.
- `req_ready  out  1`: the request is accepted this cycle.
- `configuration_wren  out  1`: to the detector's `configuration_wren`.
- `configuration_data  out  WORD_WIDTH`: to the detector's `configuration_data`.
- `pending  out  THREAD_COUNT`: one bit per thread; set while a write is queued for it.
- `idle  out  1`: high when `pending` is all zero and `configuration_wren` is 0.

## Operation

- Storage:
  - One slot per thread: `slot_data[t]` (`WORD_WIDTH` bits) plus `pending[t]`.
  - There is no FIFO; at most one outstanding write per thread.
- Accept rules:
  - `req_ready` is combinational.
  - Non-broadcast: `req_ready` = ~`pending[req_thread]` | (`issue` & `next_thread` == `req_thread`).
  - Broadcast: `req_ready` = (`pending` & ~issue_mask) == 0, where issue_mask is the one-hot mask of `next_thread` when `issue` is high.
  - A transfer happens when `req_valid` & `req_ready` are both high at the clock edge.
- On transfer:
  - Non-broadcast: `slot_data[req_thread]` <= `req_data` and `pending[req_thread]` <= 1.
  - Broadcast: every `slot_data[t]` <= `req_data` and all `pending` bits <= 1.
- Issue:
  - `issue` = `pending[next_thread]`.
  - At the edge, `configuration_wren` <= `issue` and `configuration_data` <= `slot_data[next_thread]`.
  - Also at the edge, `pending[next_thread]` <= 0, unless a same-edge transfer sets it again.
- Simultaneous issue and accept on the same thread: the issued (old) data goes out and the new data is queued. Accept wins on the `pending` bit.
- When `configuration_wren` is 0, `configuration_data` holds its last value.
- Ordering:
  - Writes to one thread reach the detector in acceptance order.
  - Writes to different threads are issued in thread-rotation order, not acceptance order.
- Reset (`reset_n` low, at any time, including mid-operation):
  - `pending` = 0, `configuration_wren` = 0, `configuration_data` = 0, `slot_data` = 0.
  - Queued writes are dropped.
  - `req_ready` follows its equation from the cleared state, so it is 1 during reset; no transfer takes effect while reset is held.

## Timing

- Accept-to-issue latency for thread t: 1 to `THREAD_COUNT` cycles. `configuration_wren` goes high in the first cycle, after the accept edge, in which the detector's current write thread equals t.
- Alignment: `configuration_wren` and `configuration_data` are registered from `next_thread`. They are therefore valid in the same cycle that the detector's `thread_write` equals the issued thread, with zero skew.
- Throughput:
  - At most one write per cycle.
  - A full broadcast completes in `THREAD_COUNT` consecutive cycles, with `configuration_wren` high in each of them.
- `idle` is registered-derived (no combinational path from `req_*`).
- `next_thread` must come from the same counter instance as the detector's write address; the two share no reset.

## Structure

- Shared package `octavo_thread_pkg`:
  - Constants for `THREAD_COUNT` and `THREAD_COUNT_WIDTH`.
  - Thread-number typedef.
  - Function `thread_onehot(thread)` returning a `THREAD_COUNT`-bit mask.
- Sub-module `config_slot`:
  - Holds one thread's data register and pending bit, with set, clear, load and broadcast-load inputs.
  - Instantiated `THREAD_COUNT` times via generate.
- Top level contains only the accept logic, the `next_thread` read mux and the output registers.

## Test plan

- **Single write.** After reset, `next_thread` rotating from 0. Accept thread 5 with data 0x123 while `next_thread`=2 → `configuration_wren`=1 with data 0x123 exactly in the cycle `next_thread`=6 (current thread 5); `pending[5]` clears; `idle` returns to 1.
- **Back-pressure.** Thread 3 pending; offer thread 3 again with `next_thread`=0 → `req_ready`=0. Offer it again when `next_thread`=3 → `req_ready`=1. Old data issues at current thread 3; new data issues one rotation (8 cycles) later.
- **Broadcast.** Broadcast 0xABC with `pending`=0 → `configuration_wren` high for 8 consecutive cycles, all carrying 0xABC. During that window, offering a broadcast gives `req_ready`=0 until only the final issuing slot remains pending.
- **Mixed order.** Accept thread 7 then thread 1 while `next_thread`=0 → thread 1 issues before thread 7.
- **Reset mid-operation.** Assert `reset_n`=0 with `pending`=8'hFF → outputs go to 0 asynchronously. After release, no `configuration_wren` until a new request is accepted.
- **Continuous stream.** Random requests over 1000 cycles → scoreboard shows every accepted write issued exactly once, in its thread's slot, with per-thread order preserved.
